// File: rtl/cir_fifo_reader.sv
// Read engine for cir_fifo: pops on credit, fixed 1-cycle read latency, out_valid 2 cycles after first pop.
// Two-entry in-order skid buffer holds out_valid/out_data stable under backpressure; pops stall when full.
module cir_fifo_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] rd_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;
  logic [1:0]       r_cnt;
  logic             r_inflight;
  logic [CNT_W-1:0] r_rd_count;

  logic [1:0]       w_occ;
  logic [1:0]       w_occ_net;
  logic             w_pop;
  logic             w_push;
  logic             w_rd;

  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = r_buf0;
  assign busy      = (r_state != ST_IDLE);
  assign rd_count  = r_rd_count;

  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_inflight;
  assign w_occ     = r_cnt + {1'b0, r_inflight};
  assign w_occ_net = w_occ - {1'b0, w_pop};

  // rst gates the strobe combinationally so no pop can leak out while reset is held
  assign w_rd    = rst & enable & ~fifo_empty & (w_occ_net < 2'd2) & (r_state == ST_RUN);
  assign fifo_rd = w_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) w_state_nxt = (w_occ != 2'd0) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (enable)                w_state_nxt = ST_RUN;
        else if (w_occ == 2'd0)    w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_buf0 is always the head; a full buffer implies nothing is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf0 <= fifo_rd_data;
          else               r_buf1 <= fifo_rd_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_buf0 <= fifo_rd_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_count <= '0;
    end else if (cnt_clr) begin
      r_rd_count <= '0;
    end else if (w_pop) begin
      r_rd_count <= r_rd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cir_fifo_reader.sv
// Bench for cir_fifo_reader: queue-based FIFO and stream model, randomized traffic plus directed scenarios.
module tb_cir_fifo_reader;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic       out_ready;
  logic       cnt_clr;
  logic [7:0] fifo_rd_data;

  logic        fifo_rd, out_valid, busy;
  logic [7:0]  out_data;
  logic [15:0] rd_count;
  logic        fifo_rd4, out_valid4, busy4;
  logic [7:0]  out_data4;
  logic [3:0]  rd_count4;

  always #5 clk = ~clk;

  cir_fifo_reader #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_rd_data(fifo_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .cnt_clr(cnt_clr), .rd_count(rd_count)
  );

  cir_fifo_reader #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd4),
    .fifo_rd_data(fifo_rd_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .busy(busy4), .cnt_clr(cnt_clr), .rd_count(rd_count4)
  );

  int errors = 0;
  int checks = 0;

  // reference state: source FIFO contents, delivered-stream buffer, one in-flight word
  logic [7:0] fq[$];
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit         m_inf;
  logic [7:0] m_inf_w;
  int         m_st;
  int         m_cnt;
  int         rd_pulses;
  int         valid_cycles;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_inf   = 1'b0;
    m_inf_w = 8'h00;
    m_st    = S_IDLE;
    m_cnt   = 0;
  endtask

  task automatic preload(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fifo_rd"},   fifo_rd, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_rd_count"},  rd_count, 0);
    chk({tag, "_rd_count4"}, rd_count4, 0);
  endtask

  // one clock: drive at negedge, compare after settling, advance model at posedge
  task automatic cycle(input bit en, input bit rdy, input bit clr);
    int         occ;
    bit         pop;
    bit         exp_rd;
    logic [7:0] dummy;
    enable     = en;
    out_ready  = rdy;
    cnt_clr    = clr;
    fifo_empty = (fq.size() == 0);
    #1;
    pop    = rst && (mq.size() > 0) && rdy;
    occ    = mq.size() + int'(m_inf);
    exp_rd = rst && en && (fq.size() > 0) && ((occ - int'(pop)) < 2) && (m_st == S_RUN);
    if (!rst) begin
      check_zero("rst");
      chk("rst_fifo_rd4", fifo_rd4, 0);
    end else begin
      chk("fifo_rd",    fifo_rd,    exp_rd);
      chk("fifo_rd4",   fifo_rd4,   exp_rd);
      chk("out_valid",  out_valid,  mq.size() > 0);
      chk("out_valid4", out_valid4, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("out_data",  out_data,  mq[0]);
        chk("out_data4", out_data4, mq[0]);
      end
      chk("busy",      busy,      m_st != S_IDLE);
      chk("busy4",     busy4,     m_st != S_IDLE);
      chk("rd_count",  rd_count,  m_cnt % 65536);
      chk("rd_count4", rd_count4, m_cnt % 16);
    end
    if (exp_rd) rd_pulses++;
    if (rst && mq.size() > 0) valid_cycles++;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (pop) begin
        got.push_back(mq[0]);
        dummy = mq.pop_front();
      end
      if (m_inf) mq.push_back(m_inf_w);
      case (m_st)
        S_IDLE:  if (en) m_st = S_RUN;
        S_RUN:   if (!en) m_st = (occ > 0) ? S_DRAIN : S_IDLE;
        default: if (en) m_st = S_RUN; else if (occ == 0) m_st = S_IDLE;
      endcase
      if (clr)      m_cnt = 0;
      else if (pop) m_cnt = m_cnt + 1;
      m_inf = exp_rd;
      if (exp_rd) m_inf_w = fq.pop_front();
    end
    #1;
    if (exp_rd) fifo_rd_data = m_inf_w;
    fifo_empty = (fq.size() == 0);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) cycle(en, rdy, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_st != S_IDLE || mq.size() > 0 || m_inf) && k < 50) begin
      cycle(1'b0, 1'b1, 1'b0);
      k++;
    end
    chk("drain_budget", k < 50, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    out_ready    = 1'b0;
    cnt_clr      = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = 8'h00;
    rd_pulses    = 0;
    valid_cycles = 0;
    model_reset();
    #2 rst = 1'b0;
    @(negedge clk);

    // reset held with a non-empty FIFO and enable high
    preload(3, 8'h80);
    run(4, 1'b1, 1'b1);
    chk("t1_fifo_rd", fifo_rd, 0);
    rst = 1'b1;
    fq.delete();

    // 16-word stream at full throughput
    preload(16, 8'h00);
    got.delete();
    rd_pulses = 0;
    valid_cycles = 0;
    run(22, 1'b1, 1'b1);
    chk("t2_rd_pulses", rd_pulses, 16);
    chk("t2_valid_cycles", valid_cycles, 16);
    chk("t2_got_size", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t2_order", got[i], i);
    chk("t2_rd_count", rd_count, 16);
    chk("t2_rd_count4", rd_count4, 0);
    drain();

    // backpressure: only two pops outstanding against a stalled consumer
    preload(5, 8'h00);
    got.delete();
    rd_pulses = 0;
    run(8, 1'b1, 1'b0);
    chk("t3_rd_pulses_stalled", rd_pulses, 2);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_data_held", out_data, 8'h00);
    run(10, 1'b1, 1'b1);
    chk("t3_rd_pulses_total", rd_pulses, 5);
    chk("t3_got_size", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("t3_order", got[i], i);
    drain();

    // enable drops while a pop is in flight
    preload(6, 8'h40);
    got.delete();
    rd_pulses = 0;
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("t4_busy_drain", busy, 1);
    drain();
    chk("t4_rd_pulses", rd_pulses, 1);
    chk("t4_got_size", got.size(), 1);
    if (got.size() > 0) chk("t4_word", got[0], 8'h40);
    chk("t4_busy_idle", busy, 0);
    fq.delete();

    // counter wrap and clear priority
    cycle(1'b0, 1'b1, 1'b1);
    preload(17, 8'h10);
    run(24, 1'b1, 1'b1);
    drain();
    chk("t5_rd_count4_wrap", rd_count4, 1);
    chk("t5_rd_count", rd_count, 17);
    preload(2, 8'h60);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("t5_clr_vs_pop", rd_count, 0);
    chk("t5_clr_vs_pop4", rd_count4, 0);
    drain();

    // async reset with the buffer full
    preload(6, 8'hA0);
    run(4, 1'b1, 1'b0);
    chk("t6_full_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    check_zero("t6_async");
    model_reset();
    run(2, 1'b1, 1'b1);
    rst = 1'b1;
    got.delete();
    run(12, 1'b1, 1'b1);
    drain();
    chk("t6_got_size", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t6_resume", got[i], 8'hA2 + i);

    // randomized traffic
    fq.delete();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 40 && fq.size() < 32) fq.push_back(8'($urandom_range(0, 255)));
      cycle($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
